// File: rtl/scrypt_sweep_ctrl.sv
// Nonce-sweep controller: hands out one nonce per job to NCH scrypt channels,
// compares returned hashes against a target and reports the first winner.

module scrypt_sweep_ch #(
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue,
  input  logic               done_in,
  input  logic [639:0]       job,
  input  logic [255:0]       hash,
  input  logic [255:0]       target,
  output logic               busy,
  output logic               done_vld,
  output logic               win,
  output logic [639:0]       data,
  output logic [NONCE_W-1:0] nonce
);
  logic         busy_q, busy_d;
  logic [639:0] data_q, data_d;

  // a pulse on an idle channel is stale and must not count or compare
  assign done_vld = done_in & busy_q;
  assign win      = done_vld && (hash < target);
  assign busy     = busy_q;
  assign data     = issue ? job : data_q;
  assign nonce    = data_q[NONCE_W-1:0];

  always_comb begin
    busy_d = busy_q;
    data_d = data_q;
    if (issue) begin
      busy_d = 1'b1;
      data_d = job;
    end else if (done_vld) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
    end
  end
endmodule

module scrypt_sweep_ctrl #(
  parameter int NCH     = 2,
  parameter int NONCE_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [639:0]         header,
  input  logic [NONCE_W-1:0]   nonce_first,
  input  logic [NONCE_W-1:0]   nonce_last,
  input  logic [255:0]         target,
  output logic [NCH*640-1:0]   core_data,
  output logic [NCH-1:0]       core_start,
  input  logic [NCH-1:0]       core_done,
  input  logic [NCH*256-1:0]   core_hash,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic [31:0]          hash_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  localparam logic [NONCE_W:0] ONE = 1;

  state_t               state_q, state_d;
  logic [639:NONCE_W]   hdr_q, hdr_d;
  logic [255:0]         target_q, target_d;
  logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
  logic [NONCE_W:0]     total_q, total_d, issued_q, issued_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [31:0]          hash_count_q, hash_count_d;

  logic [NCH-1:0]               issue_vec, ch_busy, ch_dvld, ch_win;
  logic [NCH-1:0][639:0]        ch_data;
  logic [NCH-1:0][NONCE_W-1:0]  ch_nonce;
  logic [639:0]                 job_data;
  logic                         can_issue, win_hit, last_issue;
  logic [NONCE_W-1:0]           win_nonce;
  logic [3:0]                   done_cnt;
  logic [32:0]                  hash_sum;
  logic                         unused_hdr_nonce;

  assign unused_hdr_nonce = ^header[NONCE_W-1:0];
  assign job_data = {hdr_q, next_nonce_q};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    scrypt_sweep_ch #(.NONCE_W(NONCE_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .issue    (issue_vec[i]),
      .done_in  (core_done[i]),
      .job      (job_data),
      .hash     (core_hash[i*256 +: 256]),
      .target   (target_q),
      .busy     (ch_busy[i]),
      .done_vld (ch_dvld[i]),
      .win      (ch_win[i]),
      .data     (ch_data[i]),
      .nonce    (ch_nonce[i])
    );
  end

  // lowest idle channel gets the job; lowest winning channel gets latched
  always_comb begin
    issue_vec = '0;
    can_issue = (state_q == RUN) && (issued_q != total_q);
    win_hit   = 1'b0;
    win_nonce = '0;
    done_cnt  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (can_issue && !ch_busy[i]) begin
        issue_vec[i] = 1'b1;
        can_issue    = 1'b0;
      end
      if (ch_win[i] && !win_hit) begin
        win_hit   = 1'b1;
        win_nonce = ch_nonce[i];
      end
      done_cnt = done_cnt + {3'b0, ch_dvld[i]};
    end
  end

  assign last_issue = (|issue_vec) && ((issued_q + ONE) == total_q);
  assign hash_sum   = {1'b0, hash_count_q} + {29'b0, done_cnt};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (last_issue || (win_hit && !found_q) || abort) state_d = DRAIN;
      DRAIN: if ((ch_busy & ~ch_dvld) == '0) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hdr_d         = hdr_q;
    target_d      = target_q;
    next_nonce_d  = next_nonce_q;
    total_d       = total_q;
    issued_d      = issued_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    hash_count_d  = hash_count_q;
    if (state_q == IDLE && start) begin
      hdr_d         = header[639:NONCE_W];
      target_d      = target;
      next_nonce_d  = nonce_first;
      total_d       = {1'b0, nonce_last - nonce_first} + ONE;
      issued_d      = '0;
      found_d       = 1'b0;
      found_nonce_d = '0;
      hash_count_d  = '0;
    end else begin
      if (|issue_vec) begin
        next_nonce_d = next_nonce_q + 1'b1;
        issued_d     = issued_q + ONE;
      end
      hash_count_d = hash_sum[32] ? 32'hFFFF_FFFF : hash_sum[31:0];
      if (win_hit && !found_q) begin
        found_d       = 1'b1;
        found_nonce_d = win_nonce;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q         <= '0;
      target_q      <= '0;
      next_nonce_q  <= '0;
      total_q       <= '0;
      issued_q      <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      hash_count_q  <= '0;
    end else begin
      hdr_q         <= hdr_d;
      target_q      <= target_d;
      next_nonce_q  <= next_nonce_d;
      total_q       <= total_d;
      issued_q      <= issued_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      hash_count_q  <= hash_count_d;
    end
  end

  always_comb begin
    core_start  = issue_vec;
    core_data   = ch_data;
    busy        = (state_q == RUN) || (state_q == DRAIN);
    done        = (state_q == FIN);
    found       = found_q;
    found_nonce = found_nonce_q;
    hash_count  = hash_count_q;
  end
endmodule

// File: tb/tb_scrypt_sweep_ctrl.sv
// Scoreboard bench for scrypt_sweep_ctrl: directed sweeps against a latency-based
// core model; expected issues and end-of-sweep results are queued and checked by a monitor.

module tb_scrypt_sweep_ctrl;
  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [639:0]  header;
  logic [31:0]   nonce_first, nonce_last;
  logic [255:0]  target;
  logic [1279:0] core_data;
  logic [1:0]    core_start, core_done;
  logic [511:0]  core_hash;
  logic          busy, done, found;
  logic [31:0]   found_nonce, hash_count;

  logic [1:0]    mdl_done = '0, stale_done;
  logic [511:0]  mdl_hash = '0;
  int            cnt [2];
  int            lat [2];
  logic [31:0]   mn  [2];
  logic [31:0]   wa, wb;

  typedef struct { int ch; logic [639:0] data; } iss_t;
  typedef struct { logic f; logic [31:0] n; logic [31:0] c; } fin_t;
  iss_t iq[$];
  fin_t fq[$];
  iss_t mon_e;
  fin_t mon_f;
  logic [639:0] cur_hdr;
  int errors = 0, checks = 0, dones_seen = 0;

  always #5 clk = ~clk;

  assign core_done = mdl_done | stale_done;
  assign core_hash = (|stale_done) ? {2{256'd1}} : mdl_hash;

  scrypt_sweep_ctrl #(.NCH(2), .NONCE_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .header(header),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
    .core_data(core_data), .core_start(core_start), .core_done(core_done),
    .core_hash(core_hash), .busy(busy), .done(done), .found(found),
    .found_nonce(found_nonce), .hash_count(hash_count)
  );

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // core model: done pulse lat cycles after the start pulse; winners hash to 1
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mdl_done[i] = 1'b0;
      if (rst) cnt[i] = 0;
      else begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            mdl_done[i] = 1'b1;
            mdl_hash[i*256 +: 256] = (mn[i] == wa || mn[i] == wb) ? 256'd1 : {256{1'b1}};
          end
        end
        if (core_start[i]) begin
          cnt[i] = lat[i];
          mn[i]  = core_data[i*640 +: 32];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (core_start[i]) begin
          if (iq.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_issue: got ch%0d nonce %0h want no issue", i, core_data[i*640 +: 32]);
          end else begin
            mon_e = iq.pop_front();
            chk("iss_ch", 640'(i), 640'(mon_e.ch));
            chk("iss_data", core_data[i*640 +: 640], mon_e.data);
          end
        end
      end
      if (done) begin
        dones_seen++;
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_done: got done pulse want none");
        end else begin
          mon_f = fq.pop_front();
          chk("found", 640'(found), 640'(mon_f.f));
          chk("found_nonce", 640'(found_nonce), 640'(mon_f.n));
          chk("hash_count", 640'(hash_count), 640'(mon_f.c));
          chk("busy_at_done", 640'(busy), 640'(0));
        end
      end
    end
  end

  task automatic push_iss(input int ch, input logic [31:0] n);
    iss_t e;
    e.ch = ch;
    e.data = {cur_hdr[639:32], n};
    iq.push_back(e);
  endtask

  task automatic push_fin(input logic f, input logic [31:0] n, input logic [31:0] c);
    fin_t e;
    e.f = f; e.n = n; e.c = c;
    fq.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    int  d0;
    bit  ok;
    d0 = dones_seen;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (dones_seen != d0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got no done want done within 400 cycles", nm);
    end
    repeat (4) @(negedge clk);
    #1;
    chk({nm, "_iss_left"}, 640'(iq.size()), 640'(0));
    chk({nm, "_fin_left"}, 640'(fq.size()), 640'(0));
    iq.delete();
    fq.delete();
  endtask

  task automatic sweep(input logic [31:0] f, input logic [31:0] l, input logic [255:0] tg, input string nm);
    nonce_first = f; nonce_last = l; target = tg; header = cur_hdr;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1 chk({nm, "_busy_c1"}, 640'(busy), 640'(1));
    wait_done(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stale_done = '0;
    header = '0; nonce_first = '0; nonce_last = '0; target = '0;
    lat[0] = 5; lat[1] = 5; wa = 32'hDEAD0000; wb = 32'hDEAD0000;
    cur_hdr = {{19{32'hC0DE0001}}, 32'hFFFFFFFF};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", 640'(busy), 640'(0));
    chk("rst_done", 640'(done), 640'(0));
    chk("rst_found", 640'(found), 640'(0));
    chk("rst_fnonce", 640'(found_nonce), 640'(0));
    chk("rst_hcount", 640'(hash_count), 640'(0));
    chk("rst_cstart", 640'(core_start), 640'(0));
    chk("rst_cdata", 640'(core_data), 640'(0));

    // plain range, no winner
    push_iss(0, 32'h10); push_iss(1, 32'h11); push_iss(0, 32'h12); push_iss(1, 32'h13);
    push_fin(1'b0, 32'h0, 32'd4);
    sweep(32'h10, 32'h13, 256'd0, "plain");

    // winner on 0x12, one job still outstanding when it lands
    cur_hdr = {{19{32'h5A5A1234}}, 32'h0};
    wa = 32'h12; wb = 32'h12;
    push_iss(0, 32'h10); push_iss(1, 32'h11); push_iss(0, 32'h12); push_iss(1, 32'h13);
    push_fin(1'b1, 32'h12, 32'd4);
    sweep(32'h10, 32'h13, 256'd2, "win12");

    // early winner on a wider range stops issuing
    wa = 32'h10; wb = 32'h10;
    push_iss(0, 32'h10); push_iss(1, 32'h11);
    push_fin(1'b1, 32'h10, 32'd2);
    sweep(32'h10, 32'h17, 256'd2, "early_win");

    // wrap through zero
    cur_hdr = {{19{32'h0F0F0F0F}}, 32'h12345678};
    wa = 32'hDEAD0000; wb = 32'hDEAD0000;
    push_iss(0, 32'hFFFFFFFE); push_iss(1, 32'hFFFFFFFF); push_iss(0, 32'h0); push_iss(1, 32'h1);
    push_fin(1'b0, 32'h0, 32'd4);
    sweep(32'hFFFFFFFE, 32'h00000001, 256'd0, "wrap");

    // both channels complete in the same cycle with winners
    lat[0] = 6; lat[1] = 5; wa = 32'h20; wb = 32'h21;
    push_iss(0, 32'h20); push_iss(1, 32'h21);
    push_fin(1'b1, 32'h20, 32'd2);
    sweep(32'h20, 32'h21, 256'd2, "dual_win");
    lat[0] = 5; wa = 32'hDEAD0000; wb = 32'hDEAD0000;

    // abort three cycles in
    push_iss(0, 32'h100); push_iss(1, 32'h101);
    push_fin(1'b0, 32'h0, 32'd2);
    nonce_first = 32'h100; nonce_last = 32'hFFFF; target = '0; header = cur_hdr;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_done("abort");

    // reset mid-run, then a stale completion
    push_iss(0, 32'h200); push_iss(1, 32'h201);
    nonce_first = 32'h200; nonce_last = 32'hFFFF; target = {256{1'b1}};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mrst_busy", 640'(busy), 640'(0));
    chk("mrst_done", 640'(done), 640'(0));
    chk("mrst_found", 640'(found), 640'(0));
    chk("mrst_fnonce", 640'(found_nonce), 640'(0));
    chk("mrst_hcount", 640'(hash_count), 640'(0));
    chk("mrst_cstart", 640'(core_start), 640'(0));
    chk("mrst_cdata", 640'(core_data), 640'(0));
    chk("mrst_iss_left", 640'(iq.size()), 640'(0));
    @(negedge clk) stale_done = 2'b01;
    @(negedge clk) stale_done = 2'b00;
    @(negedge clk); #1;
    chk("stale_hcount", 640'(hash_count), 640'(0));
    chk("stale_found", 640'(found), 640'(0));
    chk("stale_busy", 640'(busy), 640'(0));

    // start accepted again after reset
    cur_hdr = {{19{32'hABCD0000}}, 32'h55555555};
    push_iss(0, 32'h10); push_iss(1, 32'h11); push_iss(0, 32'h12); push_iss(1, 32'h13);
    push_fin(1'b0, 32'h0, 32'd4);
    sweep(32'h10, 32'h13, 256'd0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scrypt_sweep_ctrl.md
# scrypt_sweep_ctrl

Multi-channel nonce-sweep controller for the scrypt hashing datapath. It takes an 80-byte block header, a nonce range and a 256-bit target, and dispatches one nonce per job to `NCH` independent scrypt hash channels. It compares each returned hash against the target and reports the first winning nonce, or reports range exhaustion. It sits between the host/register interface and an array of scrypt hash cores. It replaces single-shot, single-nonce hashing with a managed sweep.

## Interface
Parameters:
- `NCH`, 2: number of scrypt hash channels (1..8).
- `NONCE_W`, 32: nonce width; the nonce occupies header bits `[NONCE_W-1:0]`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: stop issuing new jobs, drain outstanding jobs, finish with `found`=0 unless a match has already been latched.
- `header` in 640: block header; bits `[639:NONCE_W]` are fixed, and the nonce field is replaced per job.
- `nonce_first` in NONCE_W: first nonce of the range.
- `nonce_last` in NONCE_W: last nonce of the range, inclusive.
- `target` in 256: a hash is a winner if hash < target, unsigned.
- `core_data` out NCH*640: per-channel job header; channel i occupies slice `[i*640 +: 640]`.
- `core_start` out NCH: per-channel 1-cycle job pulse.
- `core_done` in NCH: per-channel 1-cycle completion pulse.
- `core_hash` in NCH*256: per-channel hash; valid in the cycle `core_done[i]`=1.
- `busy` out 1: sweep in progress.
- `done` out 1: 1-cycle end-of-sweep pulse.
- `found` out 1: a winner was latched; held until the next accepted `start`.
- `found_nonce` out NONCE_W: the winning nonce; held until the next accepted `start`.
- `hash_count` out 32: number of completed hashes in the current sweep; saturates at 2^32-1.

## Operation
- State machine states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - `start`=1 latches `header`, `nonce_first`, `nonce_last` and `target`.
  - It sets `next_nonce` = `nonce_first`, clears `found`, `found_nonce` and `hash_count`, and moves to RUN.
- RUN issues jobs:
  - Each cycle, at most one job goes to the lowest-index idle channel.
  - An issued job drives `core_start[i]` and `core_data[i]` = {header[639:NONCE_W], next_nonce}.
  - Per-channel registers store the header and nonce; `core_data[i]` is held stable until that channel's `core_done`.
  - The channel is then marked busy and `next_nonce` increments modulo 2^NONCE_W.
- Range:
  - The sweep covers ((`nonce_last` - `nonce_first`) mod 2^NONCE_W) + 1 nonces and wraps through 0.
  - `nonce_first` == `nonce_last` means exactly one nonce.
  - `nonce_last` == `nonce_first`-1 means the full 2^NONCE_W space.
  - The issued-job counter is NONCE_W+1 bits so the full range terminates.
- Completion:
  - `core_done[i]` clears channel i to idle and increments `hash_count`.
  - If `core_hash[i]` < target and `found`=0, it latches `found`=1 and `found_nonce` = the nonce stored for that channel.
- Simultaneous `core_done` pulses on several channels:
  - All are counted.
  - Among winners in the same cycle, the lowest channel index is latched.
  - Later winners never overwrite an earlier one.
- RUN goes to DRAIN when any of these occurs: the last nonce is issued, `found` becomes 1, or `abort`=1. No further `core_start` is issued after that.
- DRAIN waits until all channels are idle. Late completions still count, but cannot replace an already-latched winner.
- FIN: `done`=1 for one cycle, then IDLE.
- `start` while `busy`=1 is ignored. `abort` in IDLE or FIN is ignored.
- A `core_done[i]` for a channel that is not busy is ignored: no count and no compare.

## Timing
- Reset values:
  - `busy`, `done`, `found`, `core_start`: 0.
  - `found_nonce`, `hash_count`, `core_data`: 0.
  - State: IDLE.
- Reset mid-sweep: all channel busy flags clear. Stale `core_done` pulses after reset are ignored.
- Cycle numbering, with `start` sampled high at the edge ending cycle 0:
  - `busy`=1 from cycle 1.
  - The first `core_start[0]` is in cycle 1, `core_start[1]` in cycle 2, and so on, one issue per cycle.
- A channel that completes (`core_done` in cycle k) can be re-issued no earlier than cycle k+1.
- Compare result: `found` and `found_nonce` are visible in cycle k+1 after `core_done` in cycle k.
- `done` is asserted in the cycle after the last busy channel clears. `busy` falls in the same cycle as `done`.
- `abort` sampled in cycle k: no `core_start` in cycle k+1 or later.

## Test plan
- NCH=2, range 0x10..0x13, target 0; cores return after 5 cycles.
  - Exactly 4 `core_start` pulses, with nonces 0x10, 0x11, 0x12, 0x13.
  - `hash_count`=4, `found`=0, one `done` pulse.
- Same range; the core returns hash 0x...01 for nonce 0x12 only; target = 0x...02.
  - `found`=1, `found_nonce`=0x12, no issue after the match.
  - Outstanding job drained before `done`.
- Wrap range `nonce_first`=0xFFFFFFFE, `nonce_last`=0x00000001, target 0.
  - Nonces issued: 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
  - `hash_count`=4.
- Both channels pulse `core_done` in the same cycle with winning hashes (nonces 0x20 on ch0, 0x21 on ch1).
  - `found_nonce`=0x20.
  - `hash_count` increments by 2.
- `abort` asserted 3 cycles into a large range.
  - No further `core_start`.
  - `done` after in-flight jobs return, with `found`=0.
- `rst` asserted mid-RUN, then a stale `core_done[0]` pulse.
  - All outputs 0.
  - `hash_count` stays 0.
  - State IDLE; `start` is accepted afterwards.
